// File: rtl/alu_seq_pkg.sv
// Shared types for the ALU op sequencer: opcodes, FSM states and opcode legality.
package alu_seq_pkg;

  localparam int OP_W = 3;

  typedef enum logic [OP_W-1:0] {
    OP_ADD = 3'd0,
    OP_SUB = 3'd1,
    OP_AND = 3'd2,
    OP_OR  = 3'd3,
    OP_XOR = 3'd4,
    OP_MUL = 3'd5
  } op_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_MUL  = 2'd2,
    S_DONE = 2'd3
  } state_e;

  // Opcodes 6 and 7 have no operation behind them.
  function automatic logic is_illegal_op(input logic [OP_W-1:0] op);
    return (op > OP_MUL);
  endfunction

endpackage

// File: rtl/alu_seq_shift_mul.sv
// Iterative shift-add multiplier: loads on start, then retires one multiplier bit per cycle.
module alu_seq_shift_mul
  import alu_seq_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic               start,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               done,
  output logic [2*WIDTH-1:0] product
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  logic [2*WIDTH-1:0] mcand;
  logic [2*WIDTH-1:0] acc;
  logic [2*WIDTH-1:0] acc_next;
  logic [WIDTH-1:0]   mplier;
  logic [CW-1:0]      cnt;
  logic               active;

  // The final step's addition is folded into product so the controller can capture it on the same edge.
  assign acc_next = mplier[0] ? (acc + mcand) : acc;
  assign product  = acc_next;
  assign done     = active && (cnt == LAST);

  // Load operands on start, otherwise perform one shift-add step per cycle while active.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      mcand  <= '0;
      acc    <= '0;
      mplier <= '0;
      cnt    <= '0;
      active <= 1'b0;
    end else if (start) begin
      mcand  <= {{WIDTH{1'b0}}, a};
      acc    <= '0;
      mplier <= b;
      cnt    <= '0;
      active <= 1'b1;
    end else if (active) begin
      acc    <= acc_next;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      cnt    <= cnt + CW'(1);
      if (done) begin
        active <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/alu_op_sequencer.sv
// ALU op sequencer: accepts one request, runs a single-cycle op or an iterative multiply, holds the result until taken.
module alu_op_sequencer
  import alu_seq_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic               req_valid,
  output logic               req_ready,
  input  logic [OP_W-1:0]    req_op,
  input  logic [WIDTH-1:0]   req_a,
  input  logic [WIDTH-1:0]   req_b,
  output logic               rsp_valid,
  input  logic               rsp_ready,
  output logic [2*WIDTH-1:0] rsp_result,
  output logic               rsp_carry,
  output logic               rsp_zero,
  output logic               rsp_err,
  output logic               busy
);

  state_e             state;
  logic [OP_W-1:0]    op_q;
  logic [WIDTH-1:0]   a_q;
  logic [WIDTH-1:0]   b_q;

  logic [WIDTH:0]     sum;
  logic [WIDTH-1:0]   exec_low;
  logic               exec_carry;
  logic               exec_err;
  logic [2*WIDTH-1:0] exec_result;

  logic               mul_start;
  logic               mul_done;
  logic [2*WIDTH-1:0] mul_product;

  // The multiplier takes its operands straight from the request at the accept edge.
  assign mul_start = (state == S_IDLE) && req_valid && (req_op == OP_MUL);

  alu_seq_shift_mul #(.WIDTH(WIDTH)) u_mul (
    .clk     (clk),
    .resetn  (resetn),
    .start   (mul_start),
    .a       (req_a),
    .b       (req_b),
    .done    (mul_done),
    .product (mul_product)
  );

  // Single-cycle logic/arithmetic ops on the latched operands; only the low half is ever populated.
  always_comb begin
    sum        = {1'b0, a_q} + {1'b0, b_q};
    exec_low   = '0;
    exec_carry = 1'b0;
    exec_err   = 1'b0;
    case (op_q)
      OP_ADD: begin
        exec_low   = sum[WIDTH-1:0];
        exec_carry = sum[WIDTH];
      end
      OP_SUB: begin
        exec_low   = a_q - b_q;
        exec_carry = (a_q < b_q);
      end
      OP_AND:  exec_low = a_q & b_q;
      OP_OR:   exec_low = a_q | b_q;
      OP_XOR:  exec_low = a_q ^ b_q;
      default: exec_err = is_illegal_op(op_q);
    endcase
  end

  assign exec_result = {{WIDTH{1'b0}}, exec_low};

  // Control FSM with registered handshake outputs and result/flag registers.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state      <= S_IDLE;
      op_q       <= '0;
      a_q        <= '0;
      b_q        <= '0;
      rsp_result <= '0;
      rsp_carry  <= 1'b0;
      rsp_zero   <= 1'b0;
      rsp_err    <= 1'b0;
      req_ready  <= 1'b1;
      rsp_valid  <= 1'b0;
      busy       <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (req_valid) begin
            op_q      <= req_op;
            a_q       <= req_a;
            b_q       <= req_b;
            req_ready <= 1'b0;
            busy      <= 1'b1;
            state     <= (req_op == OP_MUL) ? S_MUL : S_EXEC;
          end
        end
        S_EXEC: begin
          rsp_result <= exec_result;
          rsp_carry  <= exec_carry;
          rsp_zero   <= (exec_result == '0);
          rsp_err    <= exec_err;
          rsp_valid  <= 1'b1;
          state      <= S_DONE;
        end
        S_MUL: begin
          if (mul_done) begin
            rsp_result <= mul_product;
            rsp_carry  <= 1'b0;
            rsp_zero   <= (mul_product == '0);
            rsp_err    <= 1'b0;
            rsp_valid  <= 1'b1;
            state      <= S_DONE;
          end
        end
        S_DONE: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            busy      <= 1'b0;
            req_ready <= 1'b1;
            state     <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Directed testbench for alu_op_sequencer with hand-computed expectations (WIDTH=8).
module tb_alu_op_sequencer;

  localparam int WIDTH = 8;

  logic               clk;
  logic               resetn;
  logic               req_valid;
  logic               req_ready;
  logic [2:0]         req_op;
  logic [WIDTH-1:0]   req_a;
  logic [WIDTH-1:0]   req_b;
  logic               rsp_valid;
  logic               rsp_ready;
  logic [2*WIDTH-1:0] rsp_result;
  logic               rsp_carry;
  logic               rsp_zero;
  logic               rsp_err;
  logic               busy;

  int vectors;
  int miscompares;

  alu_op_sequencer #(.WIDTH(WIDTH)) dut (
    .clk        (clk),
    .resetn     (resetn),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_op     (req_op),
    .req_a      (req_a),
    .req_b      (req_b),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_result (rsp_result),
    .rsp_carry  (rsp_carry),
    .rsp_zero   (rsp_zero),
    .rsp_err    (rsp_err),
    .busy       (busy)
  );

  // Free-running 10-unit clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_output(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    vectors++;
    assert (observed === expected) else begin
      miscompares++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Present one request and let it be accepted on the next edge.
  task automatic apply_stimulus(input logic [2:0] op, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    req_valid = 1'b1;
    req_op    = op;
    req_a     = a;
    req_b     = b;
    tick();
    req_valid = 1'b0;
    req_op    = 3'd0;
    req_a     = '0;
    req_b     = '0;
  endtask

  // Directed sequence.
  initial begin
    vectors     = 0;
    miscompares = 0;
    req_valid   = 1'b0;
    req_op      = 3'd0;
    req_a       = '0;
    req_b       = '0;
    rsp_ready   = 1'b0;
    resetn      = 1'b1;
    #1 resetn   = 1'b0;
    repeat (2) @(posedge clk);
    #1 resetn   = 1'b1;

    $display("[TB] reset state");
    check_output("rst_req_ready", 32'(req_ready), 32'd1);
    check_output("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check_output("rst_busy", 32'(busy), 32'd0);
    check_output("rst_result", 32'(rsp_result), 32'd0);
    check_output("rst_flags", {29'd0, rsp_carry, rsp_zero, rsp_err}, 32'd0);

    $display("[TB] ADD 200+100");
    rsp_ready = 1'b1;
    apply_stimulus(3'd0, 8'd200, 8'd100);
    check_output("add_exec_valid", 32'(rsp_valid), 32'd0);
    check_output("add_exec_ready", 32'(req_ready), 32'd0);
    tick();
    check_output("add_valid", 32'(rsp_valid), 32'd1);
    check_output("add_result", 32'(rsp_result), 32'h002C);
    check_output("add_carry", 32'(rsp_carry), 32'd1);
    check_output("add_zero", 32'(rsp_zero), 32'd0);
    tick();
    check_output("add_idle_valid", 32'(rsp_valid), 32'd0);
    check_output("add_idle_ready", 32'(req_ready), 32'd1);
    check_output("add_idle_hold", 32'(rsp_result), 32'h002C);

    $display("[TB] SUB 5-5 and 3-5");
    apply_stimulus(3'd1, 8'd5, 8'd5);
    tick();
    check_output("sub0_result", 32'(rsp_result), 32'd0);
    check_output("sub0_zero", 32'(rsp_zero), 32'd1);
    check_output("sub0_carry", 32'(rsp_carry), 32'd0);
    tick();
    apply_stimulus(3'd1, 8'd3, 8'd5);
    tick();
    check_output("sub1_result", 32'(rsp_result), 32'h00FE);
    check_output("sub1_carry", 32'(rsp_carry), 32'd1);
    check_output("sub1_zero", 32'(rsp_zero), 32'd0);
    tick();

    $display("[TB] MUL 255*255");
    apply_stimulus(3'd5, 8'd255, 8'd255);
    for (int i = 0; i < WIDTH; i++) begin
      check_output("mul_wait_valid", 32'(rsp_valid), 32'd0);
      check_output("mul_wait_ready", 32'(req_ready), 32'd0);
      check_output("mul_wait_busy", 32'(busy), 32'd1);
      tick();
    end
    check_output("mul_valid", 32'(rsp_valid), 32'd1);
    check_output("mul_result", 32'(rsp_result), 32'hFE01);
    check_output("mul_flags", {29'd0, rsp_carry, rsp_zero, rsp_err}, 32'd0);
    tick();

    $display("[TB] MUL 0*77");
    apply_stimulus(3'd5, 8'd0, 8'd77);
    repeat (WIDTH - 1) tick();
    check_output("mul0_early_valid", 32'(rsp_valid), 32'd0);
    tick();
    check_output("mul0_valid", 32'(rsp_valid), 32'd1);
    check_output("mul0_result", 32'(rsp_result), 32'd0);
    check_output("mul0_zero", 32'(rsp_zero), 32'd1);
    tick();

    $display("[TB] XOR under backpressure");
    rsp_ready = 1'b0;
    apply_stimulus(3'd4, 8'hF0, 8'h0F);
    tick();
    check_output("xor_valid", 32'(rsp_valid), 32'd1);
    check_output("xor_result", 32'(rsp_result), 32'h00FF);
    for (int i = 0; i < 5; i++) begin
      req_valid = 1'b1;
      req_op    = 3'(i);
      req_a     = 8'(8'h11 * (i + 1));
      req_b     = 8'(8'h22 * (i + 1));
      tick();
      check_output("bp_valid", 32'(rsp_valid), 32'd1);
      check_output("bp_result", 32'(rsp_result), 32'h00FF);
      check_output("bp_ready", 32'(req_ready), 32'd0);
      check_output("bp_busy", 32'(busy), 32'd1);
    end
    req_valid = 1'b1;
    req_op    = 3'd7;
    req_a     = 8'h12;
    req_b     = 8'h34;
    rsp_ready = 1'b1;
    tick();
    check_output("hs_idle_valid", 32'(rsp_valid), 32'd0);
    check_output("hs_idle_ready", 32'(req_ready), 32'd1);
    check_output("hs_idle_hold", 32'(rsp_result), 32'h00FF);
    tick();
    req_valid = 1'b0;
    req_op    = 3'd0;
    check_output("ill_accept_ready", 32'(req_ready), 32'd0);
    check_output("ill_accept_busy", 32'(busy), 32'd1);
    tick();
    check_output("ill_valid", 32'(rsp_valid), 32'd1);
    check_output("ill_result", 32'(rsp_result), 32'd0);
    check_output("ill_err", 32'(rsp_err), 32'd1);
    check_output("ill_carry", 32'(rsp_carry), 32'd0);
    check_output("ill_zero", 32'(rsp_zero), 32'd1);
    tick();

    $display("[TB] reset during MUL 13*11");
    apply_stimulus(3'd5, 8'd13, 8'd11);
    repeat (3) tick();
    #2 resetn = 1'b0;
    #1;
    check_output("mrst_valid", 32'(rsp_valid), 32'd0);
    check_output("mrst_busy", 32'(busy), 32'd0);
    check_output("mrst_ready", 32'(req_ready), 32'd1);
    check_output("mrst_result", 32'(rsp_result), 32'd0);
    check_output("mrst_flags", {29'd0, rsp_carry, rsp_zero, rsp_err}, 32'd0);
    repeat (WIDTH) tick();
    check_output("mrst_hold_valid", 32'(rsp_valid), 32'd0);
    resetn = 1'b1;
    tick();
    check_output("post_rst_valid", 32'(rsp_valid), 32'd0);
    apply_stimulus(3'd0, 8'd1, 8'd1);
    check_output("add11_exec_valid", 32'(rsp_valid), 32'd0);
    tick();
    check_output("add11_valid", 32'(rsp_valid), 32'd1);
    check_output("add11_result", 32'(rsp_result), 32'd2);
    check_output("add11_flags", {29'd0, rsp_carry, rsp_zero, rsp_err}, 32'd0);
    tick();
    check_output("add11_idle", 32'(req_ready), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/alu_op_sequencer.md
Name: alu_op_sequencer

Overview:
Multi-cycle controller that sequences the ALU datapath. Requests are taken over a valid/ready handshake and operands are latched into internal D-flip-flop registers. The block runs either a single-cycle logic/arithmetic op or an iterative shift-add multiply, then holds a registered result and flags until the consumer accepts them. It sits between an instruction/issue source and the result consumer.

Parameters:
WIDTH, 8, operand width in bits (minimum 2)

Ports:
clk  input  1  system clock, all state updates on rising edge
resetn  input  1  asynchronous active-low reset
req_valid  input  1  request present
req_ready  output  1  block can accept request (high only in IDLE)
req_op  input  3  opcode: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 MUL, 6-7 illegal
req_a  input  WIDTH  operand A
req_b  input  WIDTH  operand B
rsp_valid  output  1  result available (high only in DONE)
rsp_ready  input  1  consumer accepts result
rsp_result  output  2*WIDTH  registered result
rsp_carry  output  1  ADD carry-out / SUB borrow; 0 otherwise
rsp_zero  output  1  rsp_result == 0
rsp_err  output  1  illegal opcode flag
busy  output  1  state != IDLE

Behaviour:
- Clock/reset: one clock, clk; reset resetn is asynchronous and active-low.
- Reset, asynchronous and taking effect immediately:
  - State goes to IDLE.
  - Operand, accumulator and counter registers are cleared.
  - rsp_result=0, rsp_carry=0, rsp_zero=0, rsp_err=0.
  - Outputs: rsp_valid=0, busy=0, req_ready=1.
- FSM states: IDLE, EXEC, MUL, DONE.
- IDLE:
  - req_ready=1.
  - On req_valid&&req_ready at an edge: latch op, a, b.
  - Go to MUL if op==5, else to EXEC.
  - MUL entry sets acc=0, cnt=0, mcand={WIDTH'0,a}, mplier=b.
- EXEC: one cycle. At the next edge, register result/flags and go to DONE.
  - ADD: result={WIDTH'0, (a+b) mod 2^WIDTH}; carry = bit WIDTH of the sum.
  - SUB: result low half = (a-b) mod 2^WIDTH, upper half 0; carry=1 iff a<b.
  - AND/OR/XOR: bitwise on the low half, upper half 0; carry=0.
  - Op 6/7: result=0, err=1, carry=0.
- MUL: each edge performs:
  - if mplier[0], acc += mcand;
  - mcand <<= 1; mplier >>= 1; cnt++.
  - On the edge where cnt==WIDTH-1, write the final acc (including that step) to rsp_result and go to DONE.
  - carry=0, err=0.
- Latency, counted from the accept edge to the first cycle rsp_valid=1:
  - 1 cycle for non-MUL ops.
  - WIDTH cycles for MUL.
- DONE:
  - rsp_valid=1.
  - rsp_result/flags held stable indefinitely while rsp_ready=0.
  - On rsp_valid&&rsp_ready at an edge: go to IDLE. Outputs keep their last values; only rsp_valid drops.
- zero flag: computed from the full 2*WIDTH result at the register-write edge.
- req_valid outside IDLE is ignored; there is no queuing.
- Minimum spacing between accepts is 3 cycles for non-MUL ops.
- Simultaneous rsp_ready and req_valid in DONE: only the response handshake occurs. The request is accepted next cycle in IDLE.
- Reset mid-EXEC/MUL/DONE: the op is discarded and no response is produced.
- req_op/req_a/req_b are sampled only at the accept edge. Later changes have no effect.
- MUL wrap: a 2*WIDTH product never overflows the result; 255*255 = 0xFE01 for WIDTH=8.

Decomposition:
- Package alu_seq_pkg:
  - opcode enum (OP_ADD..OP_MUL) and the OP_W=3 constant;
  - FSM state enum;
  - illegal-opcode check function.
- One sub-module, alu_seq_shift_mul:
  - iterative shift-add multiplier holding mcand/mplier/acc/cnt;
  - inputs start, a, b; outputs done, product.
  - The controller instantiates it and owns the FSM, handshakes, single-cycle ops and result registers.

Test Plan:
1. Hold resetn=0 for 2 cycles, then release -> req_ready=1, rsp_valid=0, busy=0, rsp_result=0, all flags 0.
2. ADD a=200 b=100, rsp_ready=1 -> rsp_valid exactly 1 cycle after accept; result=0x002C, carry=1, zero=0; back to IDLE next cycle.
3. SUB a=5 b=5 -> result=0, zero=1, carry=0. Then SUB a=3 b=5 -> result=0x00FE, carry=1, zero=0.
4. MUL a=255 b=255 -> req_ready=0 and busy=1 throughout; rsp_valid first high 8 cycles after accept; result=0xFE01. Also MUL a=0 b=77 -> result=0, zero=1.
5. Backpressure and illegal op: XOR a=0xF0 b=0x0F with rsp_ready=0 for 5 cycles and req_valid=1 toggling ops:
   - rsp_valid and result=0x00FF stay stable; req_ready=0; no new accept.
   - Raise rsp_ready -> handshake, then IDLE.
   - Op 7 -> result=0, err=1.
6. Reset mid-op: assert resetn=0 asynchronously at cycle 4 of MUL 13*11 -> outputs clear immediately, no rsp_valid. Then ADD 1+1 -> result=2, normal latency.
